// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU widths, BIST controller states and default MISR taps.
package cpu_pkg;

    localparam int CPU_CTRL_W = 3;
    localparam int CPU_DATA_W = 16;

    localparam logic [CPU_DATA_W-1:0] MISR_POLY_DEFAULT = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_e;

endpackage

// File: rtl/alu_bist_if.sv
// ALU-side bus of the BIST controller: control/operands out, result/zero flag back.
interface alu_bist_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
);

    logic [CPU_CTRL_W-1:0] ALU_ctrl;
    logic [DATA_W-1:0]     in0;
    logic [DATA_W-1:0]     in1;
    logic                  zero;
    logic [DATA_W-1:0]     ALU_output;

    modport master (
        output ALU_ctrl,
        output in0,
        output in1,
        input  zero,
        input  ALU_output
    );

    modport slave (
        input  ALU_ctrl,
        input  in0,
        input  in1,
        output zero,
        output ALU_output
    );

endinterface

// File: rtl/misr16.sv
// Multiple-input signature register: shift left, fold the top bit back through POLY, xor in data.
module misr16
    import cpu_pkg::*;
#(
    parameter int                WIDTH = CPU_DATA_W,
    parameter logic [WIDTH-1:0]  POLY  = MISR_POLY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sig_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    // Clear wins over enable so a new run never folds in a stale capture.
    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: sweeps control codes and operands, compresses results into a MISR.
module alu_bist
    import cpu_pkg::*;
#(
    parameter int                DATA_W     = CPU_DATA_W,
    parameter int                CTRL_N     = 5,
    parameter int                SWEEP_N    = 16,
    parameter logic [DATA_W-1:0] IN0_SEED   = DATA_W'(16'h0001),
    parameter logic [DATA_W-1:0] IN1_SEED   = DATA_W'(16'h00F2),
    parameter logic [DATA_W-1:0] MISR_POLY  = DATA_W'(MISR_POLY_DEFAULT),
    parameter logic [DATA_W-1:0] GOLDEN_SIG = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] signature,
    output logic [7:0]        zero_err_cnt,
    alu_bist_if.master        alu
);

    localparam int                    IDX_W     = (SWEEP_N > 1) ? $clog2(SWEEP_N) : 1;
    localparam logic [CPU_CTRL_W-1:0] LAST_CTRL = CPU_CTRL_W'(CTRL_N - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(SWEEP_N - 1);

    bist_state_e           state_q, state_d;
    logic [CPU_CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0]     in0_q, in0_d;
    logic [DATA_W-1:0]     in1_q, in1_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            zcnt_q, zcnt_d;

    logic launch;
    logic last_vec;
    logic zero_err;
    logic misr_clr;
    logic misr_en;

    assign launch   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_vec = (ctrl_q == LAST_CTRL) && (idx_q == LAST_IDX);
    assign zero_err = alu.zero != (alu.ALU_output == '0);

    // APPLY gives the combinational ALU a full cycle to settle before CAPTURE samples it.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        in0_d    = in0_q;
        in1_d    = in1_q;
        idx_d    = idx_q;
        zcnt_d   = zcnt_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    ctrl_d   = '0;
                    in0_d    = IN0_SEED;
                    in1_d    = IN1_SEED;
                    idx_d    = '0;
                    zcnt_d   = '0;
                    misr_clr = 1'b1;
                    state_d  = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                misr_en = 1'b1;
                if (zero_err && (zcnt_q != 8'hFF)) begin
                    zcnt_d = zcnt_q + 8'd1;
                end
                if (last_vec) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_APPLY;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                        in1_d = in1_q + 1'b1;
                    end else begin
                        idx_d  = '0;
                        ctrl_d = ctrl_q + 1'b1;
                        in1_d  = IN1_SEED;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            idx_q   <= '0;
            zcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            idx_q   <= idx_d;
            zcnt_q  <= zcnt_d;
        end
    end

    misr16 #(
        .WIDTH (DATA_W),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (misr_clr),
        .en_i   (misr_en),
        .data_i (alu.ALU_output),
        .sig_o  (signature)
    );

    assign alu.ALU_ctrl = ctrl_q;
    assign alu.in0      = in0_q;
    assign alu.in1      = in1_q;

    assign busy         = (state_q == ST_APPLY) || (state_q == ST_CAPTURE);
    assign done         = (state_q == ST_DONE);
    assign pass         = done && (signature == GOLDEN_SIG) && (zcnt_q == 8'd0);
    assign zero_err_cnt = zcnt_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: several parameterisations, each driven by a behavioural ALU.
module tb_alu_bist;

    // Reference ALU used by every instance that needs a full set of operations.
    function automatic logic [15:0] alu_f(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] gold_sig();
        logic [15:0] s;
        logic [15:0] r;
        s = 16'h0000;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 16; i++) begin
                r = alu_f(3'(c), 16'h0001, 16'h00F2 + 16'(i));
                s = {s[14:0], 1'b0} ^ (s[15] ? 16'hB400 : 16'h0000) ^ r;
            end
        end
        return s;
    endfunction

    localparam logic [15:0] GOLD = gold_sig();

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic startA = 1'b0, startB = 1'b0, startC = 1'b0, startD = 1'b0, startE = 1'b0;
    logic busyA, doneA, passA, busyB, doneB, passB, busyC, doneC, passC;
    logic busyD, doneD, passD, busyE, doneE, passE;
    logic [15:0] sigA, sigB, sigC, sigD, sigE;
    logic [7:0]  zcA, zcB, zcC, zcD, zcE;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_bist_if #(.DATA_W(16)) ifA ();
    alu_bist_if #(.DATA_W(16)) ifB ();
    alu_bist_if #(.DATA_W(16)) ifC ();
    alu_bist_if #(.DATA_W(16)) ifD ();
    alu_bist_if #(.DATA_W(16)) ifE ();

    assign ifA.ALU_output = alu_f(ifA.ALU_ctrl, ifA.in0, ifA.in1);
    assign ifA.zero       = (ifA.ALU_output == 16'h0000);
    assign ifB.ALU_output = alu_f(ifB.ALU_ctrl, ifB.in0, ifB.in1);
    assign ifB.zero       = (ifB.ALU_output == 16'h0000);
    assign ifC.ALU_output = alu_f(ifC.ALU_ctrl, ifC.in0, ifC.in1);
    assign ifC.zero       = (ifC.ALU_output == 16'h0000);
    assign ifD.ALU_output = ifD.in0 + ifD.in1;
    assign ifD.zero       = 1'b1;
    assign ifE.ALU_output = ifE.in0 + ifE.in1;
    assign ifE.zero       = 1'b1;

    alu_bist #(.GOLDEN_SIG(GOLD)) dutA (
        .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA), .pass(passA),
        .signature(sigA), .zero_err_cnt(zcA), .alu(ifA)
    );
    alu_bist #(.CTRL_N(1), .SWEEP_N(1)) dutB (
        .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB), .pass(passB),
        .signature(sigB), .zero_err_cnt(zcB), .alu(ifB)
    );
    alu_bist #(.SWEEP_N(4), .IN1_SEED(16'hFFFE)) dutC (
        .clk(clk), .rst(rst), .start(startC), .busy(busyC), .done(doneC), .pass(passC),
        .signature(sigC), .zero_err_cnt(zcC), .alu(ifC)
    );
    alu_bist dutD (
        .clk(clk), .rst(rst), .start(startD), .busy(busyD), .done(doneD), .pass(passD),
        .signature(sigD), .zero_err_cnt(zcD), .alu(ifD)
    );
    alu_bist #(.SWEEP_N(64)) dutE (
        .clk(clk), .rst(rst), .start(startE), .busy(busyE), .done(doneE), .pass(passE),
        .signature(sigE), .zero_err_cnt(zcE), .alu(ifE)
    );

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if ({busyA, doneA, passA} !== 3'b000) $display("[TB] FAIL reset_flags got %b want 000", {busyA, doneA, passA}); else passed++;
        checks++; if (ifA.ALU_ctrl !== 3'd0) $display("[TB] FAIL reset_ctrl got %0d want 0", ifA.ALU_ctrl); else passed++;
        checks++; if ({ifA.in0, ifA.in1} !== 32'h0) $display("[TB] FAIL reset_operands got %h want 0", {ifA.in0, ifA.in1}); else passed++;
        checks++; if (sigA !== 16'h0000) $display("[TB] FAIL reset_sig got %h want 0000", sigA); else passed++;
        checks++; if (zcA !== 8'd0) $display("[TB] FAIL reset_zcnt got %0d want 0", zcA); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({busyA, doneA} !== 2'b00) $display("[TB] FAIL idle_after_reset got %b want 00", {busyA, doneA}); else passed++;
    endtask

    task automatic test_single_vector();
        int c;
        @(negedge clk); startB = 1'b1;
        @(negedge clk); startB = 1'b0;
        checks++; if (ifB.ALU_output !== 16'h00F3) $display("[TB] FAIL single_result got %h want 00F3", ifB.ALU_output); else passed++;
        c = 0;
        while (busyB && c < 20) begin
            c++;
            @(negedge clk);
        end
        checks++; if (c !== 2) $display("[TB] FAIL single_busy_cycles got %0d want 2", c); else passed++;
        checks++; if (sigB !== 16'h00F3) $display("[TB] FAIL single_sig got %h want 00F3", sigB); else passed++;
        checks++; if ({doneB, passB, zcB} !== {2'b10, 8'd0}) $display("[TB] FAIL single_status got done=%b pass=%b zc=%0d want 1 0 0", doneB, passB, zcB); else passed++;
    endtask

    task automatic test_sweep();
        int c;
        int v;
        logic [2:0]  ec;
        logic [15:0] e1;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        checks++; if (busyA !== 1'b1) $display("[TB] FAIL sweep_busy_rise got %b want 1", busyA); else passed++;
        c = 0;
        while (busyA && c < 400) begin
            if (c % 2 == 0) begin
                v  = c / 2;
                ec = 3'(v / 16);
                e1 = 16'h00F2 + 16'(v % 16);
                checks++;
                if (ifA.ALU_ctrl !== ec || ifA.in1 !== e1 || ifA.in0 !== 16'h0001)
                    $display("[TB] FAIL sweep_vec%0d got ctrl=%0d in0=%h in1=%h want ctrl=%0d in0=0001 in1=%h", v, ifA.ALU_ctrl, ifA.in0, ifA.in1, ec, e1);
                else passed++;
            end
            c++;
            @(negedge clk);
        end
        checks++; if (c !== 160) $display("[TB] FAIL sweep_busy_cycles got %0d want 160", c); else passed++;
        checks++; if (doneA !== 1'b1) $display("[TB] FAIL sweep_done got %b want 1", doneA); else passed++;
        checks++; if (sigA !== GOLD) $display("[TB] FAIL sweep_sig got %h want %h", sigA, GOLD); else passed++;
        checks++; if (zcA !== 8'd0) $display("[TB] FAIL sweep_zcnt got %0d want 0", zcA); else passed++;
        checks++; if (passA !== 1'b1) $display("[TB] FAIL sweep_pass got %b want 1", passA); else passed++;
        repeat (3) @(negedge clk);
        checks++; if ({doneA, passA} !== 2'b11) $display("[TB] FAIL sweep_hold got %b want 11", {doneA, passA}); else passed++;
    endtask

    task automatic test_in1_wrap();
        int c;
        int v;
        logic [15:0] seq [4];
        seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        @(negedge clk); startC = 1'b1;
        @(negedge clk); startC = 1'b0;
        c = 0;
        while (busyC && c < 100) begin
            if (c % 2 == 0) begin
                v = c / 2;
                checks++;
                if (ifC.in1 !== seq[v % 4] || ifC.ALU_ctrl !== 3'(v / 4))
                    $display("[TB] FAIL wrap_vec%0d got ctrl=%0d in1=%h want ctrl=%0d in1=%h", v, ifC.ALU_ctrl, ifC.in1, v / 4, seq[v % 4]);
                else passed++;
            end
            c++;
            @(negedge clk);
        end
        checks++; if (c !== 40) $display("[TB] FAIL wrap_busy_cycles got %0d want 40", c); else passed++;
    endtask

    task automatic test_zero_stuck();
        int c;
        @(negedge clk); startD = 1'b1; startE = 1'b1;
        @(negedge clk); startD = 1'b0; startE = 1'b0;
        c = 0;
        while ((busyD || busyE) && c < 1000) begin
            c++;
            @(negedge clk);
        end
        checks++; if (zcD !== 8'd80) $display("[TB] FAIL stuck_zcnt got %0d want 80", zcD); else passed++;
        checks++; if ({doneD, passD} !== 2'b10) $display("[TB] FAIL stuck_pass got done=%b pass=%b want 1 0", doneD, passD); else passed++;
        checks++; if (zcE !== 8'd255) $display("[TB] FAIL stuck_saturate got %0d want 255", zcE); else passed++;
        checks++; if (c !== 640) $display("[TB] FAIL stuck_long_cycles got %0d want 640", c); else passed++;
    endtask

    task automatic test_start_ignored_and_restart();
        int c;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        c = 0;
        while (busyA && c < 400) begin
            startA = (c == 11 || c == 12 || c == 80);
            c++;
            @(negedge clk);
        end
        startA = 1'b0;
        checks++; if (c !== 160) $display("[TB] FAIL ignore_busy_cycles got %0d want 160", c); else passed++;
        checks++; if (sigA !== GOLD) $display("[TB] FAIL ignore_sig got %h want %h", sigA, GOLD); else passed++;
        startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        checks++; if ({doneA, busyA, passA} !== 3'b010) $display("[TB] FAIL restart_flags got %b want 010", {doneA, busyA, passA}); else passed++;
        checks++; if (sigA !== 16'h0000) $display("[TB] FAIL restart_sig_clear got %h want 0000", sigA); else passed++;
        c = 0;
        while (busyA && c < 400) begin
            c++;
            @(negedge clk);
        end
        checks++; if ({doneA, passA} !== 2'b11 || c !== 160) $display("[TB] FAIL restart_complete got done=%b pass=%b cycles=%0d want 1 1 160", doneA, passA, c); else passed++;
    endtask

    task automatic test_reset_midrun();
        int c;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({busyA, doneA} !== 2'b00) $display("[TB] FAIL midrst_flags got %b want 00", {busyA, doneA}); else passed++;
        checks++; if (sigA !== 16'h0000 || ifA.ALU_ctrl !== 3'd0) $display("[TB] FAIL midrst_state got sig=%h ctrl=%0d want 0000 0", sigA, ifA.ALU_ctrl); else passed++;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        c = 0;
        while (busyA && c < 400) begin
            c++;
            @(negedge clk);
        end
        checks++; if (c !== 160) $display("[TB] FAIL midrst_rerun_cycles got %0d want 160", c); else passed++;
        checks++; if (sigA !== GOLD || zcA !== 8'd0 || passA !== 1'b1) $display("[TB] FAIL midrst_rerun got sig=%h zc=%0d pass=%b want %h 0 1", sigA, zcA, passA, GOLD); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_sweep();
        test_in1_wrap();
        test_zero_stuck();
        test_start_ignored_and_restart();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test controller for the 16-bit ALU. It drives the ALU's control and operand inputs through a deterministic sweep of control codes and operands, and captures every result into a 16-bit MISR signature. It also counts zero-flag inconsistencies and reports pass/fail against a golden signature through a start/done handshake. It sits beside the datapath ALU and owns the ALU inputs while busy; a mux outside this block selects between BIST and datapath sources.

## Interface
- DATA_W, 16: ALU data width.
- CTRL_N, 5: number of ALU control codes swept, codes 0..CTRL_N-1.
- SWEEP_N, 16: operand vectors applied per control code.
- IN0_SEED, 16'h0001: constant in0 operand.
- IN1_SEED, 16'h00F2: in1 start value, reloaded at each new control code.
- MISR_POLY, 16'hB400: MISR feedback polynomial.
- GOLDEN_SIG, 16'h0000: expected final signature.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  run request, sampled in IDLE or DONE only.
- busy  out  1  high while in APPLY or CAPTURE.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  done && signature==GOLDEN_SIG && zero_err_cnt==0.
- ALU_ctrl  out  3  control code to the ALU (registered).
- in0, in1  out  DATA_W  operands to the ALU (registered).
- zero  in  1  ALU zero flag.
- ALU_output  in  DATA_W  ALU result.
- signature  out  DATA_W  MISR contents.
- zero_err_cnt  out  8  count of vectors where zero != (ALU_output==0); saturates at 255.

## Operation
- FSM states: IDLE, APPLY, CAPTURE, DONE.
- IDLE or DONE with start=1:
  - Load ALU_ctrl=0, in0=IN0_SEED, in1=IN1_SEED.
  - Clear signature, zero_err_cnt, and the sweep index.
  - Go to APPLY.
- APPLY: operands stable for one cycle so the combinational ALU settles. Go to CAPTURE.
- CAPTURE: sample ALU_output and zero.
  - Update the MISR: sig <= {sig[14:0],1'b0} ^ (sig[15] ? MISR_POLY : 0) ^ ALU_output.
  - Increment zero_err_cnt if zero != (ALU_output==0), unless it is already 255.
  - On the last vector (ALU_ctrl==CTRL_N-1 and index==SWEEP_N-1), go to DONE.
  - Otherwise advance and go to APPLY.
- Advance rules:
  - If index < SWEEP_N-1: index+1, and in1 <= in1+1 modulo 2^DATA_W (0xFFFF wraps to 0x0000).
  - Else: index <= 0, ALU_ctrl+1, in1 <= IN1_SEED.
- DONE: outputs hold; start restarts a new run.
- start in APPLY or CAPTURE is ignored.
- in0 is constant for the whole run.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - busy=0, done=0, pass=0.
  - ALU_ctrl=0, in0=0, in1=0.
  - signature=0, zero_err_cnt=0.
- start sampled high at edge k: busy=1 and vector 0 is on the outputs after edge k.
- Each vector takes 2 cycles: APPLY then CAPTURE.
- Run length: busy for exactly 2*CTRL_N*SWEEP_N cycles (160 with defaults). done rises on the edge that ends the final CAPTURE.
- signature and zero_err_cnt update only on CAPTURE edges. They are valid when done=1.
- pass is combinational from registered state and is never high while busy.
- Reset asserted mid-run: the run aborts immediately, all outputs take their reset values, and no partial result is retained.

## Structure
- Shared package (cpu_pkg): ALU control width (3), data width (16), BIST FSM state enum, default MISR_POLY.
- Natural sub-module: `misr16`, a parameterized MISR register with clear and enable. The FSM, counters and operand registers stay in alu_bist.

## Test plan
- CTRL_N=1, SWEEP_N=1, bench ALU with code 0 = add -> ALU_output=0x00F3, signature=0x00F3, zero_err_cnt=0, busy for 2 cycles.
- Defaults, bench ALU with a correct zero flag -> sequence runs ALU_ctrl 0..4 × 16, first in1 of each code is 0x00F2 and last is 0x0101, done after 160 busy cycles, pass=1 when GOLDEN_SIG is set to the bench-computed MISR.
- Bench ALU with zero stuck at 1 and no result ever 0 -> zero_err_cnt=80, pass=0. With CTRL_N=5, SWEEP_N=64 -> zero_err_cnt saturates at 255.
- IN1_SEED=16'hFFFE, SWEEP_N=4 -> in1 sequence per code is 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- start pulsed during the run -> ignored, total busy stays at 160 cycles. start in DONE -> done drops, a new run starts, and signature is cleared.
- rst asserted at cycle 50 of a run -> same cycle: busy=0, done=0, signature=0, ALU_ctrl=0. A following start gives a result identical to a clean run.
